// File: rtl/wb_arbiter_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_multi_pkg
// Purpose  : Shared widths, exception-cause encoding and the per-source
//            writeback record used by the multi-source writeback arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wb_arbiter_multi_pkg;

   localparam int ROB_ENTRY_WIDTH = 5;
   localparam int REGISTER_WIDTH  = 5;
   localparam int DATA_WIDTH      = 32;
   localparam int ADDR_WIDTH      = 32;
   localparam int WB_NUM_SRC      = 3;

   typedef enum logic [3:0] {
      INSTR_MISALIGNED = 4'd0,
      INSTR_FAULT      = 4'd1,
      ILLEGAL_INSTR    = 4'd2,
      BREAKPOINT       = 4'd3,
      LOAD_MISALIGNED  = 4'd4,
      LOAD_FAULT       = 4'd5,
      STORE_MISALIGNED = 4'd6,
      STORE_FAULT      = 4'd7
   } excpt_cause_t;

   // One completed instruction as presented by an execution unit.
   typedef struct packed {
      logic [ROB_ENTRY_WIDTH-1:0] rob_idx;
      logic [REGISTER_WIDTH-1:0]  wr_reg;
      logic [DATA_WIDTH-1:0]      data;
      logic                       reg_wr_en;
      logic                       excpt;
      logic [ADDR_WIDTH-1:0]      tval;
      excpt_cause_t               cause;
   } wb_src_t;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_multi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_multi_rr_arbiter
// Purpose  : N-way round-robin picker. Scans req_i starting at the internal
//            pointer, wrapping at N-1. The pointer advances past the picked
//            source only when update_i says the pick was actually used.
// Ports    : clk_i, rst_ni (sync, active low), req_i[N], update_i,
//            grant_o[N] (combinational one-hot or zero)
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_multi_rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] req_i,
   input  logic         update_i,
   output logic [N-1:0] grant_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] w_win;
   logic          w_found;

   always_comb begin
      int            s;
      logic [PW-1:0] idx;
      grant_o = '0;
      w_win   = ptr_q;
      w_found = 1'b0;
      for (int o = 0; o < N; o++) begin
         s = int'(ptr_q) + o;
         if (s >= N) s = s - N;
         idx = PW'(s);
         if (!w_found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            w_win        = idx;
            w_found      = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (update_i && w_found) begin
         ptr_d = (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_multi.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_multi
// Purpose  : N-source writeback arbiter feeding the register file and the ROB
//            completion port. Three selection tiers: starved sources first,
//            then fixed-priority sources (lowest index), then round-robin.
//            The winner's record is registered (one cycle after grant).
// Ports    : clk_i, rst_ni (sync, active low), flush_i
//            req_i/reg_wr_en_i/excpt_i [NUM_SRC], flattened per-source
//            rob_idx_i, wr_reg_i, data_i, excpt_tval_i, excpt_cause_i[]
//            grant_o [NUM_SRC] combinational one-hot grant
//            reg_wr_en_o, instr_is_completed_o, instr_with_excpt_o, rob_idx_o,
//            wr_reg_o, data_to_reg_o, instr_excpt_tval_o, instr_excpt_cause_o
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_multi
   import wb_arbiter_multi_pkg::*;
#(
   parameter int                 NUM_SRC         = WB_NUM_SRC,
   parameter logic [NUM_SRC-1:0] FIXED_PRIO_MASK = NUM_SRC'(1),
   parameter int                 STARVE_LIMIT    = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                flush_i,
   input  logic [NUM_SRC-1:0]                  req_i,
   input  logic [NUM_SRC-1:0]                  reg_wr_en_i,
   input  logic [NUM_SRC-1:0]                  excpt_i,
   input  logic [NUM_SRC*ROB_ENTRY_WIDTH-1:0]  rob_idx_i,
   input  logic [NUM_SRC*REGISTER_WIDTH-1:0]   wr_reg_i,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]       data_i,
   input  logic [NUM_SRC*ADDR_WIDTH-1:0]       excpt_tval_i,
   input  excpt_cause_t [NUM_SRC-1:0]          excpt_cause_i,
   output logic [NUM_SRC-1:0]                  grant_o,
   output logic                                reg_wr_en_o,
   output logic                                instr_is_completed_o,
   output logic                                instr_with_excpt_o,
   output logic [ROB_ENTRY_WIDTH-1:0]          rob_idx_o,
   output logic [REGISTER_WIDTH-1:0]           wr_reg_o,
   output logic [DATA_WIDTH-1:0]               data_to_reg_o,
   output logic [ADDR_WIDTH-1:0]               instr_excpt_tval_o,
   output excpt_cause_t                        instr_excpt_cause_o
);

   localparam int              CW      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0]   C_LIMIT = CW'(STARVE_LIMIT);

   wb_src_t                        w_src [NUM_SRC];
   wb_src_t                        w_sel;
   logic [NUM_SRC-1:0]             w_grant;
   logic [NUM_SRC-1:0]             w_rr_grant;
   logic                           w_tier3;
   logic                           w_found;
   logic [NUM_SRC-1:0][CW-1:0]     starve_q, starve_d;

   logic                           reg_wr_en_q, reg_wr_en_d;
   logic                           completed_q, completed_d;
   logic                           with_excpt_q, with_excpt_d;
   logic [ROB_ENTRY_WIDTH-1:0]     rob_idx_q, rob_idx_d;
   logic [REGISTER_WIDTH-1:0]      wr_reg_q, wr_reg_d;
   logic [DATA_WIDTH-1:0]          data_q, data_d;
   logic [ADDR_WIDTH-1:0]          tval_q, tval_d;
   excpt_cause_t                   cause_q, cause_d;

   // Unpack the flattened per-source buses into records.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_src[gi] = '{
         rob_idx:   rob_idx_i[gi*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH],
         wr_reg:    wr_reg_i[gi*REGISTER_WIDTH +: REGISTER_WIDTH],
         data:      data_i[gi*DATA_WIDTH +: DATA_WIDTH],
         reg_wr_en: reg_wr_en_i[gi],
         excpt:     excpt_i[gi],
         tval:      excpt_tval_i[gi*ADDR_WIDTH +: ADDR_WIDTH],
         cause:     excpt_cause_i[gi]
      };
   end

   // Fixed-priority sources never enter the round-robin pool.
   wb_arbiter_multi_rr_arbiter #(
      .N (NUM_SRC)
   ) u_rr (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req_i    (req_i & ~FIXED_PRIO_MASK),
      .update_i (w_tier3),
      .grant_o  (w_rr_grant)
   );

   // Tier selection; the rr pointer only moves when tier 3 supplied the winner.
   always_comb begin
      w_grant = '0;
      w_tier3 = 1'b0;
      w_found = 1'b0;
      if (rst_ni && !flush_i) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && req_i[i] && starve_q[i] == C_LIMIT) begin
               w_grant[i] = 1'b1;
               w_found    = 1'b1;
            end
         end
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && req_i[i] && FIXED_PRIO_MASK[i]) begin
               w_grant[i] = 1'b1;
               w_found    = 1'b1;
            end
         end
         if (!w_found && (|w_rr_grant)) begin
            w_grant = w_rr_grant;
            w_tier3 = 1'b1;
         end
      end
   end

   assign grant_o = w_grant;

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_grant[i]) w_sel = w_src[i];
      end
   end

   always_comb begin
      starve_d = starve_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!req_i[i] || w_grant[i] || flush_i) starve_d[i] = '0;
         else if (starve_q[i] != C_LIMIT)         starve_d[i] = starve_q[i] + 1'b1;
      end
   end

   // Excepting instructions go to the ROB as exceptions only: no completion
   // and no register write, but the ROB still needs index/rd/data.
   always_comb begin
      reg_wr_en_d  = 1'b0;
      completed_d  = 1'b0;
      with_excpt_d = 1'b0;
      rob_idx_d    = '0;
      wr_reg_d     = '0;
      data_d       = '0;
      tval_d       = '0;
      cause_d      = excpt_cause_t'(4'd0);
      if (|w_grant) begin
         rob_idx_d = w_sel.rob_idx;
         wr_reg_d  = w_sel.wr_reg;
         data_d    = w_sel.data;
         if (w_sel.excpt) begin
            with_excpt_d = 1'b1;
            tval_d       = w_sel.tval;
            cause_d      = w_sel.cause;
         end else begin
            completed_d = 1'b1;
            reg_wr_en_d = w_sel.reg_wr_en;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         starve_q     <= '0;
         reg_wr_en_q  <= 1'b0;
         completed_q  <= 1'b0;
         with_excpt_q <= 1'b0;
         rob_idx_q    <= '0;
         wr_reg_q     <= '0;
         data_q       <= '0;
         tval_q       <= '0;
         cause_q      <= excpt_cause_t'(4'd0);
      end else begin
         starve_q     <= starve_d;
         reg_wr_en_q  <= reg_wr_en_d;
         completed_q  <= completed_d;
         with_excpt_q <= with_excpt_d;
         rob_idx_q    <= rob_idx_d;
         wr_reg_q     <= wr_reg_d;
         data_q       <= data_d;
         tval_q       <= tval_d;
         cause_q      <= cause_d;
      end
   end

   assign reg_wr_en_o          = reg_wr_en_q;
   assign instr_is_completed_o = completed_q;
   assign instr_with_excpt_o   = with_excpt_q;
   assign rob_idx_o            = rob_idx_q;
   assign wr_reg_o             = wr_reg_q;
   assign data_to_reg_o        = data_q;
   assign instr_excpt_tval_o   = tval_q;
   assign instr_excpt_cause_o  = cause_q;

endmodule
`default_nettype wire
